// File: rtl/counter_pkg.sv
// counter_pkg: counter op encoding shared by counter/timer blocks
package counter_pkg;
  typedef logic [1:0] op_t;
  localparam op_t OP_HOLD = 2'b00;
  localparam op_t OP_UP   = 2'b01;
  localparam op_t OP_DOWN = 2'b10;
  localparam op_t OP_LOAD = 2'b11;
endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc: next count and wrap flag for a modulo-N up/down counter
// UPDOWN_MOD_COUNTER_SAT_EN selects saturating instead of wrapping steps
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int CNT_MOD   = 2 ** CNT_WIDTH
) (
  input  logic [CNT_WIDTH-1:0] cur,
  input  op_t                  op,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic [CNT_WIDTH-1:0] nxt,
  output logic                 wrap
);
  localparam logic [CNT_WIDTH:0]   MOD_X = (CNT_WIDTH + 1)'(CNT_MOD);
  localparam logic [CNT_WIDTH-1:0] MAX   = CNT_WIDTH'(CNT_MOD - 1);
  logic                 up, dn, at_max, at_min;
  logic [CNT_WIDTH-1:0] clamp, up_val, dn_val;
  assign up     = en && op == OP_UP;
  assign dn     = en && op == OP_DOWN;
  assign at_max = cur == MAX;
  assign at_min = cur == '0;
  // widened compare so a full-range modulus never clamps
  assign clamp  = ({1'b0, load_val} >= MOD_X) ? MAX : load_val;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
  assign up_val = at_max ? cur : cur + CNT_WIDTH'(1);
  assign dn_val = at_min ? cur : cur - CNT_WIDTH'(1);
  assign wrap   = 1'b0;
`else
  assign up_val = at_max ? '0 : cur + CNT_WIDTH'(1);
  assign dn_val = at_min ? MAX : cur - CNT_WIDTH'(1);
  assign wrap   = (up && at_max) || (dn && at_min);
`endif
  always_comb begin
    nxt = cur;
    nxt = op == OP_LOAD ? clamp : up ? up_val : dn ? dn_val : cur;
  end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo-N up/down counter with load, clear, wrap pulse and min/max flags
// UPDOWN_MOD_COUNTER_SAT_EN selects saturating mode (Wrap stays 0)
module updown_mod_counter #(
  parameter int CNT_WIDTH = 8,
  parameter int CNT_MOD   = 2 ** CNT_WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Clear,
  input  logic                 En,
  input  logic [1:0]           CounterOp,
  input  logic [CNT_WIDTH-1:0] LoadVal,
  output logic [CNT_WIDTH-1:0] CounterOut,
  output logic                 Wrap,
  output logic                 AtMax,
  output logic                 AtMin
);
  localparam logic [CNT_WIDTH-1:0] RST_V = CNT_WIDTH'(RESET_VAL);
  localparam logic [CNT_WIDTH-1:0] MAX   = CNT_WIDTH'(CNT_MOD - 1);
  logic [CNT_WIDTH-1:0] nxt;
  logic                 wrap_nxt;
  counter_next_calc #(.CNT_WIDTH(CNT_WIDTH), .CNT_MOD(CNT_MOD)) u_next (
    .cur(CounterOut),
    .op(CounterOp),
    .en(En),
    .load_val(LoadVal),
    .nxt(nxt),
    .wrap(wrap_nxt)
  );
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CounterOut <= RST_V;
      Wrap       <= 1'b0;
    end else if (Clear) begin
      CounterOut <= RST_V;
      Wrap       <= 1'b0;
    end else begin
      CounterOut <= nxt;
      Wrap       <= wrap_nxt;
    end
  end
  assign AtMax = CounterOut == MAX;
  assign AtMin = CounterOut == '0;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed plus random checks against an arithmetic counter model
module tb_updown_mod_counter;
  localparam int W = 4, MOD = 10, RV = 0;
  localparam logic [1:0] HOLD = 2'd0, UP = 2'd1, DOWN = 2'd2, LOAD = 2'd3;
  logic         Clk = 0, Reset = 1, Clear = 0, En = 0;
  logic [1:0]   CounterOp = HOLD;
  logic [W-1:0] LoadVal = '0;
  logic [W-1:0] CounterOut;
  logic         Wrap, AtMax, AtMin;
  int checks = 0, errors = 0;
  int m = RV;
  int w = 0;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif
  updown_mod_counter #(.CNT_WIDTH(W), .CNT_MOD(MOD), .RESET_VAL(RV)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .En(En), .CounterOp(CounterOp),
    .LoadVal(LoadVal), .CounterOut(CounterOut), .Wrap(Wrap), .AtMax(AtMax), .AtMin(AtMin)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ":cnt"}, 32'(CounterOut), m);
    chk({tag, ":wrap"}, 32'(Wrap), w);
    chk({tag, ":atmax"}, 32'(AtMax), 32'(m == MOD - 1));
    chk({tag, ":atmin"}, 32'(AtMin), 32'(m == 0));
  endtask
  function automatic void model(input bit clr, input bit en, input int op, input int lv);
    w = 0;
    if (clr) m = RV;
    else if (op == 3) m = (lv >= MOD) ? MOD - 1 : lv;
    else if (en && op == 1) begin
      if (SAT) m = (m == MOD - 1) ? m : m + 1;
      else begin
        w = (m == MOD - 1);
        m = (m + 1) % MOD;
      end
    end else if (en && op == 2) begin
      if (SAT) m = (m == 0) ? 0 : m - 1;
      else begin
        w = (m == 0);
        m = (m + MOD - 1) % MOD;
      end
    end
  endfunction
  task automatic step(input string tag, input bit clr, input bit en, input logic [1:0] op, input int lv);
    @(negedge Clk);
    Clear = clr; En = en; CounterOp = op; LoadVal = W'(lv);
    @(posedge Clk);
    model(clr, en, int'(op), lv);
    #1 check_all(tag);
  endtask
  task automatic mid_reset(input string tag);
    #3 Reset = 1;
    m = RV; w = 0;
    #1 check_all({tag, ":async"});
    @(posedge Clk);
    #1 check_all({tag, ":held"});
    @(negedge Clk) Reset = 0;
    @(posedge Clk);
    model(Clear, En, int'(CounterOp), int'(LoadVal));
    #1 check_all({tag, ":release"});
  endtask
  initial begin
    #2 check_all("reset");
    @(negedge Clk) Reset = 0;
    for (int i = 0; i < 7; i++) step("up_to7", 0, 1, UP, 0);
    mid_reset("rst_mid");
    step("resume", 0, 1, UP, 0);
    step("clr0", 1, 0, HOLD, 0);
    for (int i = 0; i < 11; i++) step("up11", 0, 1, UP, 0);
    step("clr1", 1, 1, UP, 0);
    for (int i = 0; i < 3; i++) step("down3", 0, 1, DOWN, 0);
    step("clr2", 1, 1, DOWN, 0);
    step("down_wrap", 0, 1, DOWN, 0);
    mid_reset("rst_wrap");
    step("load5", 0, 1, LOAD, 5);
    step("load12", 0, 1, LOAD, 12);
    step("load15", 0, 0, LOAD, 15);
    step("load3_en0", 0, 0, LOAD, 3);
    step("clr_load", 1, 1, LOAD, 3);
    step("load7", 0, 1, LOAD, 7);
    step("en0_up", 0, 0, UP, 0);
    step("en0_down", 0, 0, DOWN, 0);
    step("hold", 0, 1, HOLD, 0);
    step("load9", 0, 1, LOAD, 9);
    step("up_at9", 0, 1, UP, 0);
    step("up_again", 0, 1, UP, 0);
    step("clr3", 1, 0, HOLD, 0);
    step("down_at0", 0, 1, DOWN, 0);
    step("down_again", 0, 1, DOWN, 0);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
